// File: rtl/ahb_apb_bdg_if.sv
// Bus bundle between the AHB-Lite fabric and the APB peripheral segment.
// Latency: none, wires only.
// Backpressure: hreadyout (AHB side) and pready (APB side) travel through this bundle.
interface ahb_apb_bdg_if #(
    parameter int AW  = 32,
    parameter int DW  = 64,
    parameter int PAW = 16
);
    // AHB-Lite side
    logic           hsel;
    logic [AW-1:0]  haddr;
    logic [1:0]     htrans;
    logic           hwrite;
    logic [2:0]     hsize;
    logic [2:0]     hburst;
    logic [3:0]     hprot;
    logic [DW-1:0]  hwdata;
    logic           hreadym;
    logic           hreadyout;
    logic [DW-1:0]  hrdata;
    logic           hresp;
    // APB4 side
    logic [PAW-1:0] paddr;
    logic           psel;
    logic           penable;
    logic           pwrite;
    logic [31:0]    pwdata;
    logic [3:0]     pstrb;
    logic [2:0]     pprot;
    logic [31:0]    prdata;
    logic           pready;
    logic           pslverr;

    // The bridge: an AHB slave that is also the APB master.
    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadym,
        input  prdata, pready, pslverr,
        output hreadyout, hrdata, hresp,
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot
    );

    // Everything around the bridge: the AHB master plus the APB peripherals.
    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadym,
        output prdata, pready, pslverr,
        input  hreadyout, hrdata, hresp,
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot
    );
endinterface

// File: rtl/ahb_apb_bdg.sv
// AHB-Lite slave to APB4 master bridge; a 64-bit access becomes two 32-bit APB beats.
// Latency: 2 AHB wait states per APB beat plus one per pready-low cycle; errors take 2 cycles.
// Backpressure: hreadyout is held low until APB completes; pready=0 stretches ACCESS.
module ahb_apb_bdg #(
    parameter int AW  = 32,
    parameter int DW  = 64,
    parameter int PAW = 16
) (
    input logic          clk,
    input logic          reset,
    ahb_apb_bdg_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
    } state_t;

    state_t         state, state_nxt;
    logic [PAW-1:0] addr_q;
    logic           write_q;
    logic [2:0]     size_q;
    logic [1:0]     prot_q;
    logic           beat_q;     // 1 while the upper word of a split is on APB
    logic [63:0]    rdata_q;
    logic [63:0]    wdata_w;
    logic           accept, illegal, split, lane, beat_ok;
    logic           unused_ok;

    assign accept  = bus.hsel & bus.htrans[1] & bus.hreadym & bus.hreadyout;
    assign illegal = (bus.hsize > 3'd3) || ((bus.hsize == 3'd3) && (DW == 32));
    assign split   = (size_q == 3'd3);
    assign beat_ok = (state == S_ACCESS) && bus.pready && !bus.pslverr;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: idle-like states accept, ACCESS waits on pready, errors go ERR1 -> ERR2
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (accept) state_nxt = illegal ? S_ERR1 : S_SETUP;
                else        state_nxt = S_IDLE;
            end
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (bus.pready) begin
                    if (bus.pslverr)          state_nxt = S_ERR1;
                    else if (split && !beat_q) state_nxt = S_SETUP;
                    else                       state_nxt = S_DONE;
                end
            end
            S_ERR1:   state_nxt = S_ERR2;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Address-phase capture on accept; beat index advances after a clean first beat
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            prot_q  <= 2'd0;
            beat_q  <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.haddr[PAW-1:0];
            write_q <= bus.hwrite;
            size_q  <= bus.hsize;
            prot_q  <= bus.hprot[1:0];
            beat_q  <= 1'b0;
        end else if (beat_ok && split) begin
            beat_q  <= 1'b1;
        end
    end

    // Read data: split beats fill their own word, narrower reads replicate into both
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if ((state == S_ACCESS) && bus.pready && !write_q) begin
            if (!split)      rdata_q <= {2{bus.prdata}};
            else if (beat_q) rdata_q[63:32] <= bus.prdata;
            else             rdata_q[31:0]  <= bus.prdata;
        end
    end

    // Byte strobes from size and low address bits; reads never strobe
    always_comb begin
        bus.pstrb = 4'h0;
        if (write_q) begin
            case (size_q)
                3'd0:    bus.pstrb = 4'b0001 << addr_q[1:0];
                3'd1:    bus.pstrb = 4'b0011 << {addr_q[1], 1'b0};
                default: bus.pstrb = 4'hF;
            endcase
        end
    end

    assign wdata_w       = 64'(bus.hwdata);
    assign lane          = split ? beat_q : ((DW == 64) && addr_q[2]);
    assign bus.pwdata    = lane ? wdata_w[63:32] : wdata_w[31:0];
    assign bus.paddr     = split ? {addr_q[PAW-1:3], beat_q, 2'b00} : addr_q;
    assign bus.pwrite    = write_q;
    assign bus.pprot     = {~prot_q[0], 1'b0, prot_q[1]};
    assign bus.psel      = (state == S_SETUP) || (state == S_ACCESS);
    assign bus.penable   = (state == S_ACCESS);
    assign bus.hreadyout = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
    assign bus.hresp     = (state == S_ERR1) || (state == S_ERR2);
    assign bus.hrdata    = rdata_q[DW-1:0];

    // Address bits above the APB window, burst type and hprot[3:2] do not affect the bridge.
    assign unused_ok = ^{bus.hburst, bus.haddr[AW-1:PAW], bus.hprot[3:2], wdata_w, rdata_q};
endmodule

// File: tb/tb_ahb_apb_bdg.sv
// Directed bench for ahb_apb_bdg with a transaction-level model and a per-cycle APB checker.
// Latency: each transfer's wait-state count is predicted from the APB responses it is given.
// Backpressure: the bench plays the APB peripheral and inserts pready-low cycles per beat.
module tb_ahb_apb_bdg;
    localparam int AW = 32, DW = 64, PAW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ahb_apb_bdg_if #(.AW(AW), .DW(DW), .PAW(PAW)) bus ();
    ahb_apb_bdg #(.AW(AW), .DW(DW), .PAW(PAW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Transaction model: the APB beats expected for the current transfer
    logic [15:0] exp_paddr [2];
    logic [31:0] exp_pwdata[2];
    logic [3:0]  exp_pstrb [2];
    logic [2:0]  exp_pprot;
    logic        exp_write, exp_err, exp_split;
    int          nexp, exp_waits, exp_done;
    // Peripheral responses per beat
    int          rw[2];
    logic [31:0] rd[2];
    logic        re[2];
    // Peripheral bookkeeping
    int          bidx, wcnt, acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample after the edge, check any APB beat, then answer as the peripheral
    task automatic cycle();
        int b;
        @(posedge clk);
        #1;
        if (bus.pready) begin
            b = (bidx < 2) ? bidx : 1;
            chk("access_len", 64'(acc), 64'(1 + rw[b]));
            bidx++;
            acc = 0;
        end
        if (bus.psel) begin
            if (bidx < nexp) begin
                chk("paddr",  64'(bus.paddr),  64'(exp_paddr[bidx]));
                chk("pwrite", 64'(bus.pwrite), 64'(exp_write));
                chk("pstrb",  64'(bus.pstrb),  64'(exp_pstrb[bidx]));
                chk("pprot",  64'(bus.pprot),  64'(exp_pprot));
                if (exp_write) chk("pwdata", 64'(bus.pwdata), 64'(exp_pwdata[bidx]));
            end else begin
                checks++;
                errors++;
                $display("FAIL psel_unexpected: got psel=1 beat=%0d expected no beat (beats=%0d)", bidx, nexp);
            end
        end
        b = (bidx < 2) ? bidx : 1;
        if (bus.psel && bus.penable) begin
            acc++;
            if (wcnt < rw[b]) begin
                wcnt++;
                bus.pready  = 1'b0;
                bus.pslverr = 1'b0;
            end else begin
                wcnt        = 0;
                bus.pready  = 1'b1;
                bus.prdata  = rd[b];
                bus.pslverr = re[b];
            end
        end else begin
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
        end
    endtask

    // Build the expected beats, wait count and response straight from the transfer rules
    task automatic plan(input logic [31:0] addr, input logic [2:0] size, input logic write,
                        input logic [63:0] wdata, input logic [3:0] prot,
                        input int w0, input logic [31:0] d0, input logic e0,
                        input int w1, input logic [31:0] d1, input logic e1);
        logic [31:0] base;
        logic [63:0] sh;
        int          ln, m, sz;
        rw[0] = w0; rd[0] = d0; re[0] = e0;
        rw[1] = w1; rd[1] = d1; re[1] = e1;
        sz        = int'(size);
        exp_split = (sz == 3);
        nexp      = (sz > 3) ? 0 : (exp_split ? 2 : 1);
        exp_write = write;
        exp_pprot = 3'((prot[0] ? 0 : 4) + (prot[1] ? 1 : 0));
        for (int i = 0; i < nexp; i++) begin
            base          = exp_split ? ((addr & ~32'h7) + 32'(4 * i)) : addr;
            exp_paddr[i]  = base[15:0];
            ln            = exp_split ? i : int'(addr[2]);
            sh            = wdata >> (32 * ln);
            exp_pwdata[i] = sh[31:0];
            m             = ((1 << (1 << sz)) - 1) << (addr % 4);
            exp_pstrb[i]  = !write ? 4'h0 : ((sz >= 2) ? 4'hF : m[3:0]);
        end
        exp_err   = (sz > 3);
        exp_waits = exp_err ? 1 : 0;
        exp_done  = 0;
        for (int i = 0; i < nexp; i++) begin
            exp_waits += 2 + rw[i];
            exp_done   = i + 1;
            if (re[i]) begin
                exp_waits += 1;
                exp_err    = 1'b1;
                break;
            end
        end
    endtask

    task automatic addr_phase(input logic [31:0] addr, input logic [2:0] size, input logic write,
                              input logic [63:0] wdata, input logic [3:0] prot);
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = addr; bus.hwrite = write;
        bus.hsize = size; bus.hprot = prot; bus.hwdata = wdata; bus.hreadym = 1'b1;
        bidx = 0; wcnt = 0; acc = 0;
        cycle();
        bus.hsel = 1'b0; bus.htrans = 2'b00;
    endtask

    task automatic xfer(input logic [31:0] addr, input logic [2:0] size, input logic write,
                        input logic [63:0] wdata, input logic [3:0] prot,
                        input int w0, input logic [31:0] d0, input logic e0,
                        input int w1, input logic [31:0] d1, input logic e1,
                        input int lit_waits, input logic [3:0] lit_strb0);
        int   waits;
        logic prev;
        plan(addr, size, write, wdata, prot, w0, d0, e0, w1, d1, e1);
        chk("model_waits", 64'(exp_waits), 64'(lit_waits));
        if (nexp > 0) chk("model_strb0", 64'(exp_pstrb[0]), 64'(lit_strb0));
        addr_phase(addr, size, write, wdata, prot);
        waits = 0;
        prev  = 1'b0;
        for (int k = 0; k < 100 && !bus.hreadyout; k++) begin
            waits++;
            prev = bus.hresp;
            cycle();
        end
        if (!bus.hreadyout) begin
            checks++;
            errors++;
            $display("FAIL timeout: got hreadyout=0 after 100 cycles expected 1");
        end
        chk("wait_states", 64'(waits), 64'(exp_waits));
        chk("hresp_last_wait", 64'(prev), 64'(exp_err));
        chk("hresp_final", 64'(bus.hresp), 64'(exp_err));
        chk("apb_beats", 64'(bidx), 64'(exp_done));
        if (!write && !exp_err)
            chk("hrdata", bus.hrdata, exp_split ? {d1, d0} : {d0, d0});
    endtask

    initial begin
        reset = 1'b1;
        bus.hsel = 1'b0; bus.haddr = '0; bus.htrans = 2'b00; bus.hwrite = 1'b0;
        bus.hsize = 3'd0; bus.hburst = 3'd0; bus.hprot = 4'd0; bus.hwdata = '0;
        bus.hreadym = 1'b1; bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
        nexp = 0; bidx = 0; wcnt = 0; acc = 0;
        rw[0] = 0; rw[1] = 0; rd[0] = '0; rd[1] = '0; re[0] = 1'b0; re[1] = 1'b0;
        exp_write = 1'b0; exp_pprot = 3'd0;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        // Reset values
        chk("rst_hreadyout", 64'(bus.hreadyout), 64'd1);
        chk("rst_hresp",     64'(bus.hresp),     64'd0);
        chk("rst_psel",      64'(bus.psel),      64'd0);
        chk("rst_penable",   64'(bus.penable),   64'd0);
        chk("rst_pwrite",    64'(bus.pwrite),    64'd0);
        chk("rst_paddr",     64'(bus.paddr),     64'd0);
        chk("rst_pstrb",     64'(bus.pstrb),     64'd0);
        chk("rst_hrdata",    bus.hrdata,         64'd0);

        // IDLE transfer with hsel: zero-wait OKAY, no APB activity
        bus.hsel = 1'b1; bus.htrans = 2'b00; bus.haddr = 32'h100;
        cycle();
        chk("idle_hreadyout", 64'(bus.hreadyout), 64'd1);
        chk("idle_hresp",     64'(bus.hresp),     64'd0);
        chk("idle_psel",      64'(bus.psel),      64'd0);
        bus.hsel = 1'b0;
        cycle();

        // Word write to upper lane
        xfer(32'h1004, 3'd2, 1'b1, 64'hAAAA5555_12345678, 4'b0011,
             0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 2, 4'hF);
        chk("model_paddr_w32",  64'(exp_paddr[0]),  64'h1004);
        chk("model_pwdata_w32", 64'(exp_pwdata[0]), 64'hAAAA5555);

        // Doubleword read, accepted back-to-back in DONE
        xfer(32'h2000, 3'd3, 1'b0, 64'h0, 4'b0010,
             0, 32'h11111111, 1'b0, 0, 32'h22222222, 1'b0, 4, 4'h0);
        chk("model_paddr_beat1", 64'(exp_paddr[1]), 64'h2004);
        chk("hrdata_split_lit",  bus.hrdata, 64'h22222222_11111111);

        // Byte write at offset 3 with three pready-low cycles
        xfer(32'h0003, 3'd0, 1'b1, 64'h0000_0000_EE00_0000, 4'b0001,
             3, 32'h0, 1'b0, 0, 32'h0, 1'b0, 5, 4'b1000);

        // Doubleword write, pslverr on the first beat
        xfer(32'h3008, 3'd3, 1'b1, 64'hDEADBEEF_01020304, 4'b0000,
             0, 32'h0, 1'b1, 0, 32'h0, 1'b0, 3, 4'hF);

        // Illegal size, accepted in ERR2 of the previous error
        xfer(32'h0010, 3'd4, 1'b0, 64'h0, 4'b0000,
             0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1, 4'h0);

        // Halfword read with one wait, halfword write in the upper lane
        xfer(32'h4006, 3'd1, 1'b0, 64'h0, 4'b0011,
             1, 32'hCAFEF00D, 1'b0, 0, 32'h0, 1'b0, 3, 4'h0);
        xfer(32'h4006, 3'd1, 1'b1, 64'h11223344_55667788, 4'b0011,
             0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 2, 4'hC);

        // Doubleword read, second beat stretched by two cycles
        xfer(32'h200C, 3'd3, 1'b0, 64'h0, 4'b0000,
             0, 32'hA5A5A5A5, 1'b0, 2, 32'h5A5A5A5A, 1'b0, 6, 4'h0);

        // Reset during ACCESS abandons the transfer
        plan(32'h6000, 3'd2, 1'b1, 64'h0000_0000_77777777, 4'b0000,
             20, 32'h0, 1'b0, 0, 32'h0, 1'b0);
        addr_phase(32'h6000, 3'd2, 1'b1, 64'h0000_0000_77777777, 4'b0000);
        cycle();
        chk("pre_rst_penable", 64'(bus.penable), 64'd1);
        reset = 1'b1;
        cycle();
        chk("mid_rst_psel",      64'(bus.psel),      64'd0);
        chk("mid_rst_penable",   64'(bus.penable),   64'd0);
        chk("mid_rst_hreadyout", 64'(bus.hreadyout), 64'd1);
        reset = 1'b0;
        cycle();

        // A normal read after the abandoned transfer
        xfer(32'h5004, 3'd2, 1'b0, 64'h0, 4'b0000,
             0, 32'h0BADBEEF, 1'b0, 0, 32'h0, 1'b0, 2, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
